// File: rtl/data_mem_responder_if.sv
// Request/response bus between a load/store initiator and the data memory
// responder.
//
// Handshake: a request transfers on a rising clk edge where req_valid and
// req_ready are both 1. The request fields (memRead, memWrite, address,
// writeData, funct3) only need to be stable on that edge. The responder then
// raises rsp_valid for exactly one cycle. rsp_err and readData are meaningful
// only while rsp_valid is 1. No response back-pressure exists.
interface data_mem_responder_if;
  logic        req_valid;
  logic        req_ready;
  logic        memRead;
  logic        memWrite;
  logic [31:0] address;
  logic [31:0] writeData;
  logic [2:0]  funct3;
  logic        rsp_valid;
  logic [31:0] readData;
  logic        rsp_err;

  modport master (
    output req_valid, memRead, memWrite, address, writeData, funct3,
    input  req_ready, rsp_valid, readData, rsp_err
  );

  modport slave (
    input  req_valid, memRead, memWrite, address, writeData, funct3,
    output req_ready, rsp_valid, readData, rsp_err
  );
endinterface

// File: rtl/data_mem_responder.sv
// Fixed-latency RV32I data memory responder. One request is handled at a
// time. The responder goes IDLE -> (WAIT) -> RESP -> IDLE. Stores commit and
// load data is registered on the edge that enters RESP.
module data_mem_responder #(
  parameter int DEPTH_WORDS = 64,
  parameter int LATENCY     = 2
) (
  input  logic                 clk,
  input  logic                 reset,
  data_mem_responder_if.slave  bus,
  output logic [1:0]           state_dbg
);

  localparam int AW = $clog2(DEPTH_WORDS);
  // The counter only needs to hold LATENCY-2.
  localparam int CW = (LATENCY > 2) ? $clog2(LATENCY - 1) : 1;
  localparam bit LAT1 = (LATENCY == 1);
  localparam logic [CW-1:0] CNT_INIT = (LATENCY >= 2) ? CW'(LATENCY - 2) : '0;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_WAIT = 2'd1;
  localparam logic [1:0] S_RESP = 2'd2;

  logic [1:0]    state;
  logic [CW-1:0] cnt;

  // Request fields captured at acceptance.
  logic          l_rd;
  logic          l_wr;
  logic [AW+1:0] l_addr;
  logic [31:0]   l_wdata;
  logic [2:0]    l_f3;

  logic          rsp_err_q;
  logic [31:0]   rdata_q;

  logic [31:0]   mem [DEPTH_WORDS];

  // Fields of the request being completed. With LATENCY=1 the request
  // completes on its own acceptance edge, so the live bus is used in IDLE.
  logic          c_rd;
  logic          c_wr;
  logic [AW+1:0] c_addr;
  logic [31:0]   c_wdata;
  logic [2:0]    c_f3;

  logic          enter_resp;
  logic [AW-1:0] idx;
  logic [31:0]   word;
  logic [7:0]    byte_sel;
  logic [15:0]   half_sel;
  logic          is_ld;
  logic          is_st;
  logic          misaligned;
  logic          bad_ld_f3;
  logic          bad_st_f3;
  logic          err;
  logic [31:0]   load_val;
  logic [3:0]    be;
  logic [31:0]   wd_sh;
  logic [31:0]   merged;
  logic          commit_st;

  assign bus.req_ready = (state == S_IDLE);
  assign bus.rsp_valid = (state == S_RESP);
  assign bus.rsp_err   = rsp_err_q;
  assign bus.readData  = rdata_q;
  assign state_dbg     = state;

  // Select live or latched request fields and decode the access.
  always_comb begin
    c_rd    = l_rd;
    c_wr    = l_wr;
    c_addr  = l_addr;
    c_wdata = l_wdata;
    c_f3    = l_f3;
    if (state == S_IDLE) begin
      c_rd    = bus.memRead;
      c_wr    = bus.memWrite;
      c_addr  = bus.address[AW+1:0];
      c_wdata = bus.writeData;
      c_f3    = bus.funct3;
    end

    enter_resp = reset &&
                 (((state == S_IDLE) && bus.req_valid && LAT1) ||
                  ((state == S_WAIT) && (cnt == '0)));

    idx      = c_addr[AW+1:2];
    word     = mem[idx];
    byte_sel = word[{c_addr[1:0], 3'b000} +: 8];
    half_sel = word[{c_addr[1], 4'b0000} +: 16];

    is_ld = c_rd && !c_wr;
    is_st = c_wr && !c_rd;

    misaligned = ((c_f3[1:0] == 2'b01) && c_addr[0]) ||
                 ((c_f3[1:0] == 2'b10) && (c_addr[1:0] != 2'b00));
    bad_ld_f3  = (c_f3 == 3'b011) || (c_f3 == 3'b110) || (c_f3 == 3'b111);
    bad_st_f3  = (c_f3[2] == 1'b1) || (c_f3[1:0] == 2'b11);

    err = (c_rd && c_wr) ||
          (is_ld && (bad_ld_f3 || misaligned)) ||
          (is_st && (bad_st_f3 || misaligned));

    case (c_f3)
      3'b000:  load_val = {{24{byte_sel[7]}}, byte_sel};
      3'b001:  load_val = {{16{half_sel[15]}}, half_sel};
      3'b010:  load_val = word;
      3'b100:  load_val = {24'd0, byte_sel};
      3'b101:  load_val = {16'd0, half_sel};
      default: load_val = 32'd0;
    endcase

    case (c_f3[1:0])
      2'b00:   be = 4'b0001 << c_addr[1:0];
      2'b01:   be = 4'b0011 << c_addr[1:0];
      default: be = 4'b1111;
    endcase
    wd_sh = c_wdata << {c_addr[1:0], 3'b000};
    for (int b = 0; b < 4; b++) begin
      merged[8*b +: 8] = be[b] ? wd_sh[8*b +: 8] : word[8*b +: 8];
    end

    commit_st = enter_resp && is_st && !err;
  end

  // Control FSM: accept in IDLE, count down in WAIT, one-cycle RESP.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state   <= S_IDLE;
      cnt     <= '0;
      l_rd    <= 1'b0;
      l_wr    <= 1'b0;
      l_addr  <= '0;
      l_wdata <= '0;
      l_f3    <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (bus.req_valid) begin
            l_rd    <= bus.memRead;
            l_wr    <= bus.memWrite;
            l_addr  <= bus.address[AW+1:0];
            l_wdata <= bus.writeData;
            l_f3    <= bus.funct3;
            if (LAT1) begin
              state <= S_RESP;
            end else begin
              state <= S_WAIT;
              cnt   <= CNT_INIT;
            end
          end
        end
        S_WAIT: begin
          if (cnt == '0) begin
            state <= S_RESP;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        S_RESP:  state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

  // Response registers, loaded on the edge entering RESP and held after.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rsp_err_q <= 1'b0;
      rdata_q   <= 32'd0;
    end else if (enter_resp) begin
      rsp_err_q <= err;
      rdata_q   <= (is_ld && !err) ? load_val : 32'd0;
    end
  end

  // Memory array has no reset; a store commits with its response.
  always_ff @(posedge clk) begin
    if (commit_st) begin
      mem[idx] <= merged;
    end
  end

endmodule
